instruction_fetch_queue: RTL and testbench

Parametrised successor to the single-register fetch stage. It decouples PC generation from decode with a prefetch FIFO of configurable depth, and handles branch, jump and jump-register redirects with queue flush and in-flight kill. Decode consumes instructions through a valid/ready handshake instead of a hazard hold. The block sits between the synchronous instruction memory (1-cycle read latency) and the decode stage.

---
 rtl/mips_fetch_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/instruction_fetch_queue.sv | 141 ++++++++++++++
 tb/tb_instruction_fetch_queue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the fetch queue: FSM states, redirect select codes,
// instruction size and a ceiling-log2 helper for sizing counters.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        RSEL_NONE     = 2'd0,
        RSEL_BRANCH   = 2'd1,
        RSEL_JUMP_INM = 2'd2,
        RSEL_JUMP_RS  = 2'd3
    } redirect_sel_t;

    localparam int INSTR_BYTES = 4;

    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a synchronous clear and an occupancy output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo
    import mips_fetch_pkg::*;
#(
    parameter int NB_DATA = 64,
    parameter int DEPTH   = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_clear,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [NB_DATA-1:0]      i_data,
    output logic [NB_DATA-1:0]      o_data,
    output logic                    o_empty,
    output logic [clogb2(DEPTH):0]  o_level
);

    localparam int NB_PTR = clogb2(DEPTH);

    logic [NB_DATA-1:0] mem [DEPTH];
    logic [NB_PTR:0]    wr_ptr;
    logic [NB_PTR:0]    rd_ptr;
    logic               full;
    logic               do_push;
    logic               do_pop;

    assign o_level = wr_ptr - rd_ptr;
    assign o_empty = (wr_ptr == rd_ptr);
    assign full    = (o_level == (NB_PTR + 1)'(DEPTH));
    assign do_push = i_push & ~full;
    assign do_pop  = i_pop & ~o_empty;
    assign o_data  = mem[rd_ptr[NB_PTR-1:0]];

    // Clear wins over a simultaneous push or pop.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (do_push && !i_clear) mem[wr_ptr[NB_PTR-1:0]] <= i_data;
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Prefetching fetch stage: issues reads to a 1-cycle instruction memory,
// buffers responses in a FIFO and handles branch/jump redirects with flush.
module instruction_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int                  NB_ADDR    = 32,
    parameter int                  NB_INSTR   = 32,
    parameter int                  NB_INM_I   = 16,
    parameter int                  NB_INM_J   = 26,
    parameter int                  FIFO_DEPTH = 4,
    parameter logic [NB_ADDR-1:0]  RESET_PC   = '0
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_valid,
    output logic [NB_ADDR-1:0]            o_imem_addr,
    output logic                          o_imem_re,
    input  logic [NB_INSTR-1:0]           i_imem_data,
    output logic [NB_INSTR-1:0]           o_ir,
    output logic [NB_ADDR-1:0]            o_pc,
    output logic                          o_ir_valid,
    input  logic                          i_ir_ready,
    input  logic                          i_branch,
    input  logic                          i_jump_inm,
    input  logic                          i_jump_rs,
    input  logic [NB_ADDR-1:0]            i_redirect_base,
    input  logic [NB_INM_I-1:0]           i_inm_i,
    input  logic [NB_INM_J-1:0]           i_inm_j,
    input  logic [NB_ADDR-1:0]            i_rs,
    output logic [clogb2(FIFO_DEPTH):0]   o_level,
    output logic                          o_redirect_err
);

    localparam int                NB_LEVEL = clogb2(FIFO_DEPTH) + 1;
    localparam int                NB_DATA  = NB_INSTR + NB_ADDR;
    localparam logic [NB_LEVEL:0] DEPTH_L  = (NB_LEVEL + 1)'(FIFO_DEPTH);
    localparam logic [NB_ADDR-1:0] STEP    = NB_ADDR'(INSTR_BYTES);

    fetch_state_t        state;
    fetch_state_t        state_next;
    redirect_sel_t       redirect_sel;
    logic                redirect_multi;
    logic                redirect;
    logic [NB_ADDR-1:0]  redirect_target;
    logic [NB_ADDR-1:0]  pc;
    logic [NB_ADDR-1:0]  pc_tag;
    logic                inflight;
    logic                credit;
    logic                issue;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic [NB_DATA-1:0]  fifo_head;

    always_comb begin
        redirect_sel    = RSEL_NONE;
        redirect_multi  = 1'b0;
        redirect_target = pc;
        case ({i_branch, i_jump_inm, i_jump_rs})
            3'b000:  redirect_sel = RSEL_NONE;
            3'b100:  redirect_sel = RSEL_BRANCH;
            3'b010:  redirect_sel = RSEL_JUMP_INM;
            3'b001:  redirect_sel = RSEL_JUMP_RS;
            default: redirect_multi = 1'b1;
        endcase
        case (redirect_sel)
            RSEL_BRANCH:   redirect_target = i_redirect_base +
                {{(NB_ADDR-NB_INM_I-2){i_inm_i[NB_INM_I-1]}}, i_inm_i, 2'b00};
            RSEL_JUMP_INM: redirect_target =
                {i_redirect_base[NB_ADDR-1 -: (NB_ADDR-NB_INM_J-2)], i_inm_j, 2'b00};
            RSEL_JUMP_RS:  redirect_target = i_rs;
            default:       redirect_target = pc;
        endcase
    end

    // Issue only when every buffered and outstanding word still has a slot.
    assign credit      = ({1'b0, o_level} + {{NB_LEVEL{1'b0}}, inflight}) < DEPTH_L;
    assign redirect    = i_valid & (redirect_sel != RSEL_NONE);
    assign issue       = i_valid & (state == S_RUN) & credit;
    assign push        = i_valid & inflight & ~redirect;
    assign pop         = i_valid & ~fifo_empty & i_ir_ready;
    assign o_imem_re   = issue;
    assign o_imem_addr = pc;
    assign o_ir_valid  = ~fifo_empty;
    assign o_ir        = fifo_empty ? '0 : fifo_head[NB_INSTR-1:0];
    assign o_pc        = fifo_empty ? '0 : fifo_head[NB_DATA-1 -: NB_ADDR];

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= S_START;
        else if (i_valid) state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_START: state_next = S_RUN;
            S_RUN:   state_next = S_RUN;
            S_FLUSH: state_next = S_RUN;
            default: state_next = S_START;
        endcase
        if (redirect) state_next = S_FLUSH;
    end

    // Dropping the in-flight flag on a redirect kills the pending response.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc             <= RESET_PC;
            pc_tag         <= '0;
            inflight       <= 1'b0;
            o_redirect_err <= 1'b0;
        end else if (i_valid) begin
            o_redirect_err <= redirect_multi;
            if (redirect) begin
                pc       <= redirect_target;
                inflight <= 1'b0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc     <= pc + STEP;
                    pc_tag <= pc + STEP;
                end
            end
        end
    end

    sync_fifo #(
        .NB_DATA (NB_DATA),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (redirect),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  ({pc_tag, i_imem_data}),
        .o_data  (fifo_head),
        .o_empty (fifo_empty),
        .o_level (o_level)
    );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: directed scenarios plus random traffic,
// with a monitor checking every accepted instruction against the program stream.
module tb_instruction_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        i_clock = 1'b0;
    logic        i_reset, i_valid, i_ir_ready;
    logic        i_branch, i_jump_inm, i_jump_rs;
    logic [31:0] i_redirect_base, i_rs;
    logic [15:0] i_inm_i;
    logic [25:0] i_inm_j;
    logic [31:0] i_imem_data = 32'h0;
    logic [31:0] o_imem_addr, o_ir, o_pc;
    logic        o_imem_re, o_ir_valid, o_redirect_err;
    logic [2:0]  o_level;

    logic [31:0] nb_base = 32'h0, nb_rs = 32'h0;
    logic [15:0] nb_inm_i = 16'h0;
    logic [25:0] nb_inm_j = 26'h0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] target_q[$];
    logic [31:0] model_addr = RESET_PC;
    int          empty_cycles = 0;

    always #5 i_clock = ~i_clock;

    // Memory model: the word stored at address A is A itself.
    always @(posedge i_clock) begin
        if (o_imem_re) i_imem_data <= o_imem_addr;
    end

    instruction_fetch_queue #(.RESET_PC(RESET_PC)) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_valid         (i_valid),
        .o_imem_addr     (o_imem_addr),
        .o_imem_re       (o_imem_re),
        .i_imem_data     (i_imem_data),
        .o_ir            (o_ir),
        .o_pc            (o_pc),
        .o_ir_valid      (o_ir_valid),
        .i_ir_ready      (i_ir_ready),
        .i_branch        (i_branch),
        .i_jump_inm      (i_jump_inm),
        .i_jump_rs       (i_jump_rs),
        .i_redirect_base (i_redirect_base),
        .i_inm_i         (i_inm_i),
        .i_inm_j         (i_inm_j),
        .i_rs            (i_rs),
        .o_level         (o_level),
        .o_redirect_err  (o_redirect_err)
    );

    function automatic logic [31:0] refTarget(input logic br, input logic ji,
                                              input logic [31:0] base, input logic [15:0] inmi,
                                              input logic [25:0] inmj, input logic [31:0] rs);
        int off;
        if (br) begin
            off = int'($signed(inmi));
            return base + 32'(off * 4);
        end
        if (ji) return (base & 32'hF000_0000) | (32'(inmj) * 32'd4);
        return rs;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs just after the edge and returns mid-cycle.
    task automatic applyStimulus(input logic rst, input logic vld, input logic rdy,
                                 input logic br, input logic ji, input logic jr);
        @(posedge i_clock);
        #1;
        i_reset         = rst;
        i_valid         = vld;
        i_ir_ready      = rdy;
        i_branch        = br;
        i_jump_inm      = ji;
        i_jump_rs       = jr;
        i_redirect_base = nb_base;
        i_inm_i         = nb_inm_i;
        i_inm_j         = nb_inm_j;
        i_rs            = nb_rs;
        if (!rst && vld && (int'(br) + int'(ji) + int'(jr) == 1))
            target_q.push_back(refTarget(br, ji, nb_base, nb_inm_i, nb_inm_j, nb_rs));
        @(negedge i_clock);
    endtask

    task automatic checkRedirect(input string name, input logic br, input logic ji,
                                 input logic jr, input logic [31:0] exp_target);
        applyStimulus(1'b0, 1'b1, 1'b1, br, ji, jr);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput({name, "_flush_re"}, 32'(o_imem_re), 32'd0);
        checkOutput({name, "_flush_valid"}, 32'(o_ir_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput({name, "_issue_re"}, 32'(o_imem_re), 32'd1);
        checkOutput({name, "_issue_addr"}, o_imem_addr, exp_target);
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every accepted instruction must be the next word of the program stream.
    always @(negedge i_clock) begin
        if (i_reset) begin
            model_addr   = RESET_PC;
            empty_cycles = 0;
            target_q.delete();
        end else if (i_valid) begin
            if (o_ir_valid && i_ir_ready) begin
                checkOutput("stream_ir", o_ir, model_addr);
                checkOutput("stream_pc", o_pc, model_addr + 32'd4);
                model_addr = model_addr + 32'd4;
            end
            if (int'(i_branch) + int'(i_jump_inm) + int'(i_jump_rs) == 1) begin
                if (target_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL redirect_queue actual=empty expected=target");
                end else begin
                    model_addr = target_q.pop_front();
                end
            end
            if (o_ir_valid) empty_cycles = 0;
            else empty_cycles++;
            if (empty_cycles > 40) begin
                checks++;
                failures++;
                $display("[TB] FAIL stall_timeout actual=%0d cycles expected<=40", empty_cycles);
                empty_cycles = 0;
            end
        end
    end

    initial begin
        i_reset = 1'b1; i_valid = 1'b1; i_ir_ready = 1'b1;
        i_branch = 1'b0; i_jump_inm = 1'b0; i_jump_rs = 1'b0;
        i_redirect_base = 32'h0; i_inm_i = 16'h0; i_inm_j = 26'h0; i_rs = 32'h0;

        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_ir_valid", 32'(o_ir_valid), 32'd0);
        checkOutput("reset_level", 32'(o_level), 32'd0);
        checkOutput("reset_re", 32'(o_imem_re), 32'd0);
        checkOutput("reset_ir", o_ir, 32'd0);
        checkOutput("reset_pc", o_pc, 32'd0);
        checkOutput("reset_err", 32'(o_redirect_err), 32'd0);

        $display("[TB] startup latency");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_idle_re", 32'(o_imem_re), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("edge1_re", 32'(o_imem_re), 32'd1);
        checkOutput("edge1_addr", o_imem_addr, RESET_PC);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("edge2_valid", 32'(o_ir_valid), 32'd0);
        checkOutput("edge2_addr", o_imem_addr, RESET_PC + 32'd4);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("edge3_valid", 32'(o_ir_valid), 32'd1);
        checkOutput("edge3_ir", o_ir, 32'h0);
        checkOutput("edge3_pc", o_pc, 32'h4);
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("stream_level", 32'(o_level), 32'd1);

        $display("[TB] backpressure");
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("full_level", 32'(o_level), 32'd4);
        checkOutput("full_re", 32'(o_imem_re), 32'd0);
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] redirects");
        nb_base = 32'h20; nb_inm_i = 16'hFFFE;
        checkRedirect("branch", 1'b1, 1'b0, 1'b0, 32'h18);
        nb_base = 32'hA000_0010; nb_inm_j = 26'h40;
        checkRedirect("jump_inm", 1'b0, 1'b1, 1'b0, 32'hA000_0100);
        nb_rs = 32'h300;
        checkRedirect("jump_rs", 1'b0, 1'b0, 1'b1, 32'h300);

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("multi_err_before", 32'(o_redirect_err), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("multi_err_pulse", 32'(o_redirect_err), 32'd1);
        checkOutput("multi_no_flush", 32'(o_imem_re), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("multi_err_after", 32'(o_redirect_err), 32'd0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] freeze and reset with read in flight");
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("freeze_level", 32'(o_level), 32'd4);
            checkOutput("freeze_re", 32'(o_imem_re), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("thaw_level", 32'(o_level), 32'd4);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("thaw_issue", 32'(o_imem_re), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rst2_level", 32'(o_level), 32'd0);
        checkOutput("rst2_valid", 32'(o_ir_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rst2_addr", o_imem_addr, RESET_PC + 32'd4);
        checkOutput("rst2_stale", 32'(o_ir_valid), 32'd0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] random traffic");
        for (int n = 0; n < 800; n++) begin
            logic rdy, vld, br, ji, jr;
            int   pick;
            rdy = ($urandom_range(0, 3) != 0);
            vld = ($urandom_range(0, 7) != 0);
            br = 1'b0; ji = 1'b0; jr = 1'b0;
            pick = int'($urandom_range(0, 39));
            nb_base  = $urandom;
            nb_inm_i = 16'($urandom);
            nb_inm_j = 26'($urandom);
            nb_rs    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
            case (pick)
                0: br = 1'b1;
                1: ji = 1'b1;
                2: jr = 1'b1;
                3: begin br = 1'b1; jr = 1'b1; end
                default: ;
            endcase
            applyStimulus(1'b0, vld, rdy, br, ji, jr);
        end
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
